// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the bell-game datapath.
//   state_t   - round_dealer FSM states
//   widths    - COLOR_W, NUM_W, SCORE_W
//   keypad    - P1_KEY, P2_KEY; MATCH_SUM is the winning number sum
//   map_num() - folds a 3-bit random value onto a card number 1..5
package game_pkg;

   typedef enum logic [2:0] {IDLE, DEAL, SHOW, GAP, DONE} state_t;

   localparam int COLOR_W   = 2;
   localparam int NUM_W     = 3;
   localparam int SCORE_W   = 8;

   localparam logic [3:0] P1_KEY = 4'b0111;
   localparam logic [3:0] P2_KEY = 4'b1001;
   localparam int MATCH_SUM = 5;

   // 0..4 -> 1..5, 5..7 -> 1..3
   function automatic logic [NUM_W-1:0] map_num(input logic [2:0] k);
      return (k < 3'd5) ? k + 3'd1 : k - 3'd4;
   endfunction

endpackage

// File: rtl/card_lfsr.sv
// card_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) plus card mapping.
// Ports:
//   clk, rst (async, active low) - reset loads SEED
//   en                           - advance one step per clk when high
//   c1, c2                       - colours from L[1:0], L[9:8]
//   n1, n2                       - numbers 1..5 from L[4:2], L[12:10]
// Card outputs are combinational views of the current LFSR value.
module card_lfsr
   import game_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic [COLOR_W-1:0] c1,
   output logic [COLOR_W-1:0] c2,
   output logic [NUM_W-1:0]   n1,
   output logic [NUM_W-1:0]   n2
);

   logic [15:0] lfsr;
   logic        fb;

   assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    lfsr <= SEED;
      else if (en) lfsr <= {lfsr[14:0], fb};
   end

   assign c1 = lfsr[1:0];
   assign c2 = lfsr[9:8];
   assign n1 = map_num(lfsr[4:2]);
   assign n2 = map_num(lfsr[12:10]);

endmodule

// File: rtl/round_dealer.sv
// round_dealer: runs the rounds of the bell game.
// Deals a card pair per round, shows it while a decaying reward `count`
// ticks down, blanks the cards for a gap, and stops after NUM_ROUNDS.
// Ports:
//   clk, rst (async, active low)
//   start        - one-cycle pulse, starts a game from IDLE or DONE
//   finish       - from score_control, a push was judged this round
//   c1/n1, c2/n2 - dealt cards, held stable until the next deal
//   count        - current reward
//   card_valid   - cards shown and pushes meaningful
//   round_no     - rounds dealt so far this game
//   game_over    - last round finished, waiting for start
// Optional build macro DEALER_MANUAL_EN adds manual_cards[9:0]
// ({c1,n1,c2,n2}) and manual_mode; with manual_mode=1 a deal takes the
// manual cards verbatim (out-of-range numbers are not corrected).
module round_dealer
   import game_pkg::*;
#(
   parameter int          TICK_DIV   = 1000,  // >= 2
   parameter int          MAX_POINTS = 100,   // 1..255
   parameter int          GAP_TICKS  = 3,     // >= 1
   parameter int          NUM_ROUNDS = 10,    // 1..255
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               finish,
`ifdef DEALER_MANUAL_EN
   input  logic [9:0]         manual_cards,
   input  logic               manual_mode,
`endif
   output logic [COLOR_W-1:0] c1,
   output logic [COLOR_W-1:0] c2,
   output logic [NUM_W-1:0]   n1,
   output logic [NUM_W-1:0]   n2,
   output logic [SCORE_W-1:0] count,
   output logic               card_valid,
   output logic [7:0]         round_no,
   output logic               game_over
);

   localparam int                 PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0]      PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [SCORE_W-1:0] MAXP     = SCORE_W'(MAX_POINTS);
   localparam logic [7:0]         GAP_N    = 8'(GAP_TICKS);
   localparam logic [7:0]         ROUNDS   = 8'(NUM_ROUNDS);

   state_t             state;
   logic [PW-1:0]      presc;
   logic [7:0]         gap_cnt;
   logic               tick, gap_hit;
   logic [COLOR_W-1:0] l_c1, l_c2, d_c1, d_c2;
   logic [NUM_W-1:0]   l_n1, l_n2, d_n1, d_n2;

   // LFSR runs whenever a game is active so deals depend on push timing
   card_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .en  (state != IDLE),
      .c1  (l_c1),
      .c2  (l_c2),
      .n1  (l_n1),
      .n2  (l_n2)
   );

`ifdef DEALER_MANUAL_EN
   always_comb begin
      {d_c1, d_n1, d_c2, d_n2} = {l_c1, l_n1, l_c2, l_n2};
      if (manual_mode) {d_c1, d_n1, d_c2, d_n2} = manual_cards;
   end
`else
   assign {d_c1, d_n1, d_c2, d_n2} = {l_c1, l_n1, l_c2, l_n2};
`endif

   assign tick = (state == SHOW || state == GAP) && (presc == PRE_LAST);

   // Gap is complete once GAP_TICKS ticks have been seen (gap_cnt saturates
   // there), or on the cycle of the final tick itself.
   assign gap_hit = (gap_cnt == GAP_N) || (tick && gap_cnt == GAP_N - 8'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         presc      <= '0;
         gap_cnt    <= '0;
         c1         <= '0;
         c2         <= '0;
         n1         <= '0;
         n2         <= '0;
         count      <= '0;
         card_valid <= 1'b0;
         round_no   <= '0;
         game_over  <= 1'b0;
      end else begin
         if (tick)                              presc <= '0;
         else if (state == SHOW || state == GAP) presc <= presc + PW'(1);

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= DEAL;
                  round_no  <= '0;
                  game_over <= 1'b0;
               end
            end
            DEAL: begin
               {c1, n1, c2, n2} <= {d_c1, d_n1, d_c2, d_n2};
               count      <= MAXP;
               round_no   <= round_no + 8'd1;
               card_valid <= 1'b1;
               presc      <= '0;
               state      <= SHOW;
            end
            SHOW: begin
               // finish wins over a same-cycle tick: count is frozen as is
               if (finish) begin
                  state      <= GAP;
                  card_valid <= 1'b0;
                  presc      <= '0;
                  gap_cnt    <= '0;
               end else if (tick) begin
                  if (count == '0) begin
                     state      <= GAP;
                     card_valid <= 1'b0;
                     gap_cnt    <= '0;
                  end else begin
                     count <= count - SCORE_W'(1);
                  end
               end
            end
            GAP: begin
               // cards and count held: score_control samples count late
               if (gap_hit && !finish) begin
                  presc <= '0;
                  if (round_no == ROUNDS) begin
                     state     <= DONE;
                     game_over <= 1'b1;
                     count     <= '0;
                  end else begin
                     state <= DEAL;
                  end
               end else if (tick && gap_cnt != GAP_N) begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
